mode_selector: RTL

- Converts one raw mode pushbutton into the 2-bit mode_sel bus that drives the mode decoder (00 clock, 01 stopwatch, 10 timer).
- Synchronises, debounces and classifies presses as short or long.
- Short press cycles the mode.
- Long press gives a stopwatch reset pulse in stopwatch mode, or returns to clock mode in any other mode.

---
 rtl/mode_selector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mode_selector.sv
// Mode pushbutton front end: synchronise, debounce, classify short/long
// presses and drive the registered mode_sel bus and its status pulses.
module mode_selector #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    output logic [1:0] mode_sel,
    output logic       mode_changed,
    output logic       sw_rst,
    output logic       btn_level
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_LONG = 2'd2;

    localparam logic [1:0] M_CLK = 2'b00;
    localparam logic [1:0] M_SW  = 2'b01;
    localparam logic [1:0] M_TMR = 2'b10;

    logic [1:0]     sync_q;
    logic           btn_sync;
    logic           level_q;
    logic           press;
    logic [DBW-1:0] db_cnt;
    logic [1:0]     state, state_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic           short_act, long_act;
    logic [1:0]     mode_n;
    logic           chg_n, swr_n;

    assign btn_sync = sync_q[1];
    assign press    = btn_level & ~level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_mode};
        end
    end

    // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b0;
            level_q   <= 1'b0;
            db_cnt    <= '0;
        end else begin
            level_q <= btn_level;
            if (btn_sync != btn_level) begin
                if (db_cnt == DB_MAX) begin
                    btn_level <= btn_sync;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        short_act = 1'b0;
        long_act  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (press) begin
                    state_n = S_HELD;
                    hold_n  = '0;
                end
            end
            S_HELD: begin
                if (!btn_level) begin
                    short_act = 1'b1;
                    state_n   = S_IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    long_act = 1'b1;
                    state_n  = S_LONG;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            S_LONG: begin
                if (!btn_level) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Unused code 11 falls back to clock mode on any press
    always_comb begin
        mode_n = mode_sel;
        chg_n  = 1'b0;
        swr_n  = 1'b0;
        if (short_act) begin
            chg_n = 1'b1;
            unique case (1'b1)
                (mode_sel == M_CLK): mode_n = M_SW;
                (mode_sel == M_SW):  mode_n = M_TMR;
                default:             mode_n = M_CLK;
            endcase
        end else if (long_act) begin
            unique case (1'b1)
                (mode_sel == M_SW):  swr_n = 1'b1;
                (mode_sel == M_CLK): chg_n = 1'b0;
                default: begin
                    mode_n = M_CLK;
                    chg_n  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            mode_sel     <= M_CLK;
            mode_changed <= 1'b0;
            sw_rst       <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            mode_sel     <= mode_n;
            mode_changed <= chg_n;
            sw_rst       <= swr_n;
        end
    end

endmodule
